// File: rtl/uart_pkg.sv
// uart_pkg: shared types and defaults for the UART receive path.
package uart_pkg;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_DEPTH = 16;
  typedef struct packed {
    logic stop_err;
    logic parity_err;
    logic [DEF_DATA_WIDTH-1:0] data;
  } rx_entry_t;
endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: first-word-fall-through buffer for received characters with sticky overflow.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DataWidth = DEF_DATA_WIDTH,
  parameter int Depth = DEF_DEPTH
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_wr_en,
  input  logic [DataWidth-1:0]       i_wr_data,
  input  logic                       i_wr_parity_error,
  input  logic                       i_wr_stop_error,
  input  logic                       i_rd_en,
  output logic [DataWidth-1:0]       o_rd_data,
  output logic                       o_rd_parity_error,
  output logic                       o_rd_stop_error,
  output logic                       o_empty,
  output logic                       o_full,
  output logic [$clog2(Depth):0]     o_count,
  output logic                       o_overflow,
  input  logic                       i_clr_overflow
);
  localparam int AW = $clog2(Depth);
  logic [AW:0] wr_ptr, rd_ptr;
  logic [DataWidth+1:0] mem [Depth];
  logic [DataWidth+1:0] head;
  logic rd_ok, wr_ok;
  assign rd_ok = i_rd_en && !o_empty;
  assign wr_ok = i_wr_en && (!o_full || rd_ok);
  assign o_empty = wr_ptr == rd_ptr;
  assign o_full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign o_count = wr_ptr - rd_ptr;
  assign head = mem[rd_ptr[AW-1:0]];
  assign o_rd_data = o_empty ? '0 : head[DataWidth-1:0];
  assign o_rd_parity_error = !o_empty && head[DataWidth];
  assign o_rd_stop_error = !o_empty && head[DataWidth+1];
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      o_overflow <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      o_overflow <= (i_wr_en && !wr_ok) ? 1'b1 : i_clr_overflow ? 1'b0 : o_overflow;
    end
  end
  // storage is not reset; a strobe coincident with reset must not land
  always_ff @(posedge i_clk) begin
    if (i_rst_n && wr_ok) mem[wr_ptr[AW-1:0]] <= {i_wr_stop_error, i_wr_parity_error, i_wr_data};
  end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: scoreboard bench; expected heads queued at write, checked by a pop monitor.
module tb_uart_rx_fifo;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic wr_en = 1'b0, par = 1'b0, stp = 1'b0, rd_en = 1'b0, clr = 1'b0;
  logic [7:0] wr_data = '0;
  logic [7:0] rd_data;
  logic rd_par, rd_stp, empty, full, overflow;
  logic [4:0] count;
  logic [9:0] q[$];
  int total = 0, bad = 0;

  uart_rx_fifo dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_wr_en(wr_en), .i_wr_data(wr_data),
    .i_wr_parity_error(par), .i_wr_stop_error(stp), .i_rd_en(rd_en),
    .o_rd_data(rd_data), .o_rd_parity_error(rd_par), .o_rd_stop_error(rd_stp),
    .o_empty(empty), .o_full(full), .o_count(count), .o_overflow(overflow),
    .i_clr_overflow(clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rd_en && !empty) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL pop: got %0h expected nothing queued", {rd_stp, rd_par, rd_data});
      end else chk("head", {rd_stp, rd_par, rd_data}, q.pop_front());
    end
  end

  task automatic step(input logic w, input logic [7:0] d, input logic p, input logic s,
                      input logic r, input logic c);
    wr_en = w; wr_data = d; par = p; stp = s; rd_en = r; clr = c;
    @(posedge clk);
    #1;
    wr_en = 0; wr_data = '0; par = 0; stp = 0; rd_en = 0; clr = 0;
  endtask

  task automatic wr(input logic [7:0] d, input logic p, input logic s, input logic exp_keep);
    if (exp_keep) q.push_back({s, p, d});
    step(1, d, p, s, 0, 0);
  endtask

  task automatic rd();
    step(0, 8'h00, 0, 0, 1, 0);
  endtask

  initial begin
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    rst_n = 1;
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_count", count, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_data", rd_data, 0);
    // single character fall-through
    wr(8'h41, 0, 0, 1);
    chk("t1_empty", empty, 0);
    chk("t1_count", count, 1);
    chk("t1_data", rd_data, 8'h41);
    rd();
    chk("t1_empty2", empty, 1);
    chk("t1_data0", rd_data, 0);
    // error flags travel with data
    wr(8'h55, 1, 0, 1);
    wr(8'hAA, 0, 1, 1);
    chk("t2_par", rd_par, 1);
    rd();
    chk("t2_stop", rd_stp, 1);
    rd();
    chk("t2_empty", empty, 1);
    chk("t2_flags0", {rd_stp, rd_par}, 0);
    // fill and overflow
    for (int i = 0; i < 16; i++) wr(8'(i), 0, 0, 1);
    wr(8'hFF, 0, 0, 0);
    chk("t3_full", full, 1);
    chk("t3_count", count, 16);
    chk("t3_ovf", overflow, 1);
    for (int i = 0; i < 16; i++) rd();
    chk("t3_empty", empty, 1);
    chk("t3_ovf_sticky", overflow, 1);
    step(0, 0, 0, 0, 0, 1);
    chk("t3_clr", overflow, 0);
    // simultaneous read+write when full
    for (int i = 0; i < 16; i++) wr(8'(8'h80 + i), 0, 0, 1);
    q.push_back({2'b00, 8'h99});
    step(1, 8'h99, 0, 0, 1, 0);
    chk("t4_full", full, 1);
    chk("t4_count", count, 16);
    chk("t4_ovf", overflow, 0);
    for (int i = 0; i < 16; i++) rd();
    chk("t4_empty", empty, 1);
    // read+write on empty, then read on empty
    q.push_back({2'b00, 8'h3C});
    step(1, 8'h3C, 0, 0, 1, 0);
    chk("t5_count", count, 1);
    chk("t5_data", rd_data, 8'h3C);
    rd();
    rd();
    chk("t5_count0", count, 0);
    chk("t5_empty", empty, 1);
    chk("t5_ovf", overflow, 0);
    // overflow set beats clear
    for (int i = 0; i < 16; i++) wr(8'(8'hC0 + i), 0, 0, 1);
    wr(8'h11, 0, 0, 0);
    chk("t6_ovf", overflow, 1);
    step(1, 8'h22, 0, 0, 0, 1);
    chk("t6_setwins", overflow, 1);
    step(0, 0, 0, 0, 0, 1);
    chk("t6_clr", overflow, 0);
    for (int i = 0; i < 16; i++) rd();
    chk("t6_empty", empty, 1);
    // reset discards contents and a coincident write
    for (int i = 0; i < 5; i++) step(1, 8'(i), 0, 0, 0, 0);
    chk("t7_count5", count, 5);
    rst_n = 0;
    step(1, 8'h77, 0, 0, 0, 0);
    rst_n = 1;
    chk("t7_count", count, 0);
    chk("t7_empty", empty, 1);
    chk("t7_data", rd_data, 0);
    chk("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
